// File: rtl/rda_sequencer.sv
// Multi-cycle recursive-doubling adder: classify, log-depth star combine, sum resolve.
// Optional RDA_EARLY_EXIT_EN: leave ITER as soon as no propagate status remains.
module rda_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned STAGES = $clog2(WIDTH) + 1;
  localparam int unsigned KW     = $clog2(STAGES);

  localparam logic [1:0] StatK = 2'b00;
  localparam logic [1:0] StatP = 2'b01;
  localparam logic [1:0] StatG = 2'b11;

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e               r_state, w_state_next;
  logic [KW-1:0]        r_k;
  logic [WIDTH:0][1:0]  r_st, w_st_init, w_st_next, w_st_res;
  logic [WIDTH-1:0]     r_a, r_b, r_sum, w_carry;
  logic                 r_cout;
  logic                 w_any_p, w_res_any_p, w_last, w_exit;

  function automatic logic [1:0] star(input logic [1:0] hi, input logic [1:0] lo);
    return (hi == StatP) ? lo : hi;
  endfunction

  always_comb begin
    w_st_init[0] = cin ? StatG : StatK;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({a[i], b[i]})
        2'b00:   w_st_init[i+1] = StatK;
        2'b11:   w_st_init[i+1] = StatG;
        default: w_st_init[i+1] = StatP;
      endcase
    end
  end

  // One doubling stage; every read uses the pre-update bank.
  always_comb begin
    w_st_next = r_st;
    for (int s = 0; s < STAGES; s++) begin
      if (r_k == KW'(s)) begin
        for (int j = (1 << s); j <= WIDTH; j++) begin
          w_st_next[j] = star(r_st[j], r_st[j - (1 << s)]);
        end
      end
    end
  end

  always_comb begin
    w_any_p = 1'b0;
    for (int j = 0; j <= WIDTH; j++) begin
      if (r_st[j] == StatP) w_any_p = 1'b1;
    end
  end

  always_comb begin
    w_last = (r_k == KW'(STAGES - 1));
`ifdef RDA_EARLY_EXIT_EN
    w_exit = !w_any_p;
`else
    w_exit = 1'b0;
`endif
    w_st_res = w_exit ? r_st : w_st_next;
    w_res_any_p = 1'b0;
    for (int j = 0; j <= WIDTH; j++) begin
      if (w_st_res[j] == StatP) w_res_any_p = 1'b1;
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_carry[i] = w_st_res[i][1];
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StIter;
      StIter:  if (w_exit || w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k    <= '0;
      r_st   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_st   <= w_st_init;
            r_k    <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
          end
        end
        StIter: begin
          if (w_exit || w_last) begin
            r_st   <= w_st_res;
            r_sum  <= r_a ^ r_b ^ w_carry;
            r_cout <= w_st_res[WIDTH][1];
          end else begin
            r_st <= w_st_next;
            r_k  <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A propagate surviving the final stage means the doubling schedule is broken.
  always_ff @(posedge clk) begin
    if (!rst && r_state == StIter && (w_exit || w_last)) begin
      assert (!w_res_any_p);
    end
  end

  assign busy = (r_state != StIdle);
  assign done = (r_state == StDone);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
